// File: rtl/fir_stream_driver.sv
// fir_stream_driver: feeds stored samples one at a time to an external FIR
// filter over a valid/ack handshake and captures each filter result into a
// result buffer readable at any time.
// Optional build macro: FIR_DRV_TIMEOUT_EN adds a watchdog on the SEND and
// WAIT_RES handshakes; without it both states wait indefinitely.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for i_start
// FETCH    | reading sample[index] into ov_sample
// SEND     | ov_sample presented, waiting for i_sample_ack
// WAIT_RES | waiting for i_result_valid, result written and acked here
// STORE    | bump index and result count, decide next sample or end
// DONE     | one-cycle o_done pulse, then back to IDLE
module fir_stream_driver #(
  parameter int DATA_WIDTH     = 24,
  parameter int MAX_SAMPLES    = 256,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int AW            = $clog2(MAX_SAMPLES)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load_we,
  input  logic [AW-1:0]         iv_load_addr,
  input  logic [DATA_WIDTH-1:0] iv_load_data,
  input  logic                  i_start,
  input  logic [AW:0]           iv_num_samples,
  output logic [DATA_WIDTH-1:0] ov_sample,
  output logic                  o_sample_valid,
  input  logic                  i_sample_ack,
  input  logic [DATA_WIDTH-1:0] iv_result,
  input  logic                  i_result_valid,
  output logic                  o_result_ack,
  input  logic [AW-1:0]         iv_rd_addr,
  output logic [DATA_WIDTH-1:0] ov_rd_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [AW:0]           ov_result_count,
  output logic                  o_timeout
);

  typedef enum logic [2:0] {IDLE, FETCH, SEND, WAIT_RES, STORE, DONE} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] sample_mem [MAX_SAMPLES];
  logic [DATA_WIDTH-1:0] result_mem [MAX_SAMPLES];
  logic [AW-1:0]         idx;
  logic [AW:0]           n_cap;
  logic [AW:0]           n_clamped;
  logic                  timeout_hit;

  // Run length requests beyond the buffer depth are limited to the depth.
  always_comb begin
    n_clamped = iv_num_samples;
    if (iv_num_samples > (AW+1)'(MAX_SAMPLES)) n_clamped = (AW+1)'(MAX_SAMPLES);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_next     = state;
    o_sample_valid = 1'b0;
    o_result_ack   = 1'b0;
    o_done         = 1'b0;
    o_busy         = 1'b1;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_next = (n_clamped == '0) ? DONE : FETCH;
      end
      FETCH: state_next = SEND;
      SEND: begin
        o_sample_valid = 1'b1;
        if (i_sample_ack)     state_next = WAIT_RES;
        else if (timeout_hit) state_next = DONE;
      end
      WAIT_RES: begin
        if (i_result_valid) begin
          o_result_ack = 1'b1;
          state_next   = STORE;
        end else if (timeout_hit) begin
          state_next = DONE;
        end
      end
      STORE: begin
        if ({1'b0, idx} == n_cap - (AW+1)'(1)) state_next = DONE;
        else                                  state_next = FETCH;
      end
      DONE: begin
        o_done     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Run bookkeeping: captured length, index, result count and sample output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      n_cap           <= '0;
      idx             <= '0;
      ov_result_count <= '0;
      ov_sample       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            n_cap           <= n_clamped;
            idx             <= '0;
            ov_result_count <= '0;
          end
        end
        FETCH: ov_sample <= sample_mem[idx];
        STORE: begin
          idx             <= idx + AW'(1);
          ov_result_count <= ov_result_count + (AW+1)'(1);
        end
        default: ;
      endcase
    end
  end

  // Sample buffer write port; the FETCH read above sees the pre-write word.
  always_ff @(posedge i_clk) begin
    if (i_load_we) sample_mem[iv_load_addr] <= iv_load_data;
  end

  // Result buffer: write on accepted result (never while reset is held), free-running read port.
  always_ff @(posedge i_clk) begin
    if (!i_rst && state == WAIT_RES && i_result_valid) result_mem[idx] <= iv_result;
    ov_rd_data <= result_mem[iv_rd_addr];
  end

`ifdef FIR_DRV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;
  logic          timeout_q;

  assign timeout_hit = (to_cnt == '0);
  assign o_timeout   = timeout_q;

  // Watchdog down-counter reloaded on every state change; terminal count ends the run.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_next != state) to_cnt <= TW'(TIMEOUT_CYCLES - 1);
      else if (to_cnt != '0)   to_cnt <= to_cnt - TW'(1);
      if (state == IDLE && i_start)
        timeout_q <= 1'b0;
      else if ((state == SEND || state == WAIT_RES) && state_next == DONE)
        timeout_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign o_timeout          = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_fir_stream_driver.sv
// Directed bench for fir_stream_driver: a table of runs driven through a
// small filter model, plus hand sequences for read-first loads, N=0,
// mid-run reset and the watchdog (when FIR_DRV_TIMEOUT_EN is defined).
module tb_fir_stream_driver;

  localparam int DW = 24;
  localparam int MS = 16;
  localparam int AW = $clog2(MS);
`ifdef FIR_DRV_TIMEOUT_EN
  localparam int LONG_WAIT = 12;
`else
  localparam int LONG_WAIT = 50;
`endif

  logic          i_clk, i_rst, i_load_we, i_start, i_sample_ack, i_result_valid;
  logic [AW-1:0] iv_load_addr, iv_rd_addr;
  logic [DW-1:0] iv_load_data, iv_result, ov_sample, ov_rd_data;
  logic [AW:0]   iv_num_samples, ov_result_count;
  logic          o_sample_valid, o_result_ack, o_busy, o_done, o_timeout;

  fir_stream_driver #(
    .DATA_WIDTH(DW), .MAX_SAMPLES(MS), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_load_we(i_load_we),
    .iv_load_addr(iv_load_addr), .iv_load_data(iv_load_data),
    .i_start(i_start), .iv_num_samples(iv_num_samples),
    .ov_sample(ov_sample), .o_sample_valid(o_sample_valid),
    .i_sample_ack(i_sample_ack), .iv_result(iv_result),
    .i_result_valid(i_result_valid), .o_result_ack(o_result_ack),
    .iv_rd_addr(iv_rd_addr), .ov_rd_data(ov_rd_data), .o_busy(o_busy),
    .o_done(o_done), .ov_result_count(ov_result_count), .o_timeout(o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    int n_req; int n_exp; int ack; int res; int mult; int base; bit noise;
  } vec_t;

  vec_t          vecs [6];
  logic [DW-1:0] samp_model [MS];
  logic [DW-1:0] res_model  [MS];
  int n_cmp = 0, n_err = 0;
  int done_cnt = 0, valid_cnt = 0, rack_cnt = 0, rack_wide = 0;
  bit rack_prev = 1'b0;

  always @(negedge i_clk) begin
    if (o_done) done_cnt++;
    if (o_sample_valid) valid_cnt++;
    if (o_result_ack) begin
      if (!rack_prev) rack_cnt++;
      else            rack_wide++;
    end
    rack_prev = o_result_ack;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic load(input int a, input logic [DW-1:0] d);
    i_load_we = 1'b1; iv_load_addr = AW'(a); iv_load_data = d;
    tick();
    i_load_we = 1'b0;
  endtask

  task automatic read_res(input int a, input logic [DW-1:0] e);
    iv_rd_addr = AW'(a);
    tick();
    chk("rd_data", ov_rd_data, e);
  endtask

  task automatic start_run(input int n);
    iv_num_samples = (AW+1)'(n);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // One filter transaction; on return the DUT is in SEND (next sample) or IDLE (last).
  task automatic filter_one(input int ack_dly, input int res_dly, input int mult,
                            input bit noise, input bit last, input logic [DW-1:0] exp_s);
    logic [DW-1:0] s;
    int t;
    t = 0;
    while (o_sample_valid !== 1'b1 && t < 300) begin tick(); t++; end
    chk("sample_valid_seen", o_sample_valid, 1);
    if (o_sample_valid !== 1'b1) return;
    s = ov_sample;
    chk("sample_value", s, exp_s);
    for (int i = 0; i < ack_dly; i++) begin
      if (noise) begin i_result_valid = 1'b1; iv_result = 'h5A5A5; end
      tick();
      i_result_valid = 1'b0;
    end
    chk("sample_hold", {o_sample_valid, ov_sample}, {1'b1, s});
    i_sample_ack = 1'b1;
    tick();
    i_sample_ack = 1'b0;
    chk("valid_drop", o_sample_valid, 0);
    for (int i = 0; i < res_dly; i++) begin
      if (noise) begin i_sample_ack = 1'b1; i_start = 1'b1; end
      tick();
      i_sample_ack = 1'b0; i_start = 1'b0;
    end
    iv_result = s * DW'(mult);
    i_result_valid = 1'b1;
    #1;
    chk("result_ack", o_result_ack, 1);
    tick();
    i_result_valid = 1'b0;
    chk("ack_low_store", o_result_ack, 0);
    tick();
    if (last) begin
      chk("done_at_end", o_done, 1);
      tick();
      chk("idle_after_done", o_busy, 0);
    end else begin
      chk("valid_low_fetch", o_sample_valid, 0);
      tick();
      chk("ack_to_valid_latency", o_sample_valid, 1);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int d0, a0;
    for (int i = 0; i < v.n_exp; i++) begin
      samp_model[i] = DW'(v.base + i);
      load(i, samp_model[i]);
    end
    d0 = done_cnt; a0 = rack_cnt;
    start_run(v.n_req);
    chk("busy_after_start", o_busy, 1);
    chk("valid_in_fetch", o_sample_valid, 0);
    tick();
    chk("start_to_valid", o_sample_valid, 1);
    for (int k = 0; k < v.n_exp; k++)
      filter_one(v.ack, v.res, v.mult, v.noise, k == v.n_exp - 1, samp_model[k]);
    chk("result_count", ov_result_count, v.n_exp);
    chk("done_pulses", done_cnt - d0, 1);
    chk("result_acks", rack_cnt - a0, v.n_exp);
    for (int k = 0; k < v.n_exp; k++) begin
      res_model[k] = DW'((v.base + k) * v.mult);
      read_res(k, res_model[k]);
    end
  endtask

  initial begin
    int v0;
    bit ok;
    vecs[0] = '{4,  4,  3, LONG_WAIT, 2, 1,      1'b0};
    vecs[1] = '{4,  4,  0, 0,         3, 1,      1'b0};
    vecs[2] = '{1,  1,  1, 2,         5, 100,    1'b0};
    vecs[3] = '{3,  3,  2, 2,         7, 'h10,   1'b1};
    vecs[4] = '{20, 16, 0, 1,         1, 'h200,  1'b0};
    vecs[5] = '{6,  6,  1, 0,         9, 'h3000, 1'b0};

    i_rst = 1'b1; i_load_we = 1'b0; iv_load_addr = '0; iv_load_data = '0;
    i_start = 1'b0; iv_num_samples = '0; i_sample_ack = 1'b0;
    iv_result = '0; i_result_valid = 1'b0; iv_rd_addr = '0;
    tick(); tick();
    chk("rst_valid", o_sample_valid, 0);
    chk("rst_rack", o_result_ack, 0);
    chk("rst_done", o_done, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_sample", ov_sample, 0);
    chk("rst_count", ov_result_count, 0);
    i_rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Load into the index being fetched: old word seen now, new word next run.
    load(0, 'h111);
    start_run(1);
    i_load_we = 1'b1; iv_load_addr = '0; iv_load_data = 'h222;
    tick();
    i_load_we = 1'b0;
    chk("read_first", ov_sample, 'h111);
    filter_one(0, 0, 1, 1'b0, 1'b1, 'h111);
    start_run(1);
    tick();
    filter_one(0, 0, 1, 1'b0, 1'b1, 'h222);
    res_model[0] = 'h222;

    // N=0: done one cycle after start, no sample ever presented.
    v0 = valid_cnt;
    start_run(0);
    chk("n0_done", o_done, 1);
    chk("n0_busy", o_busy, 1);
    tick();
    chk("n0_done_low", o_done, 0);
    chk("n0_idle", o_busy, 0);
    chk("n0_no_valid", valid_cnt - v0, 0);

    // Reset while waiting for the second result, with a result arriving on that edge.
    for (int i = 0; i < 3; i++) begin
      samp_model[i] = DW'('h40 + i);
      load(i, samp_model[i]);
    end
    start_run(3);
    tick();
    filter_one(0, 0, 4, 1'b0, 1'b0, 'h40);
    res_model[0] = 'h100;
    i_sample_ack = 1'b1;
    tick();
    i_sample_ack = 1'b0;
    tick();
    i_result_valid = 1'b1; iv_result = 'hDEAD; i_rst = 1'b1;
    tick();
    i_result_valid = 1'b0;
    chk("mid_rst_valid", o_sample_valid, 0);
    chk("mid_rst_rack", o_result_ack, 0);
    chk("mid_rst_done", o_done, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_timeout", o_timeout, 0);
    chk("mid_rst_sample", ov_sample, 0);
    chk("mid_rst_count", ov_result_count, 0);
    i_rst = 1'b0;
    read_res(1, res_model[1]);
    read_res(0, res_model[0]);

`ifdef FIR_DRV_TIMEOUT_EN
    // Ack withheld: 16 SEND cycles, then DONE with the sticky flag set.
    start_run(2);
    tick();
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (o_sample_valid !== 1'b1) ok = 1'b0;
    end
    chk("to_valid_held", ok, 1);
    tick();
    chk("to_done", o_done, 1);
    chk("to_flag", o_timeout, 1);
    chk("to_valid_drop", o_sample_valid, 0);
    chk("to_count", ov_result_count, 0);
    tick();
    chk("to_idle", o_busy, 0);
    chk("to_sticky", o_timeout, 1);
    start_run(0);
    chk("to_clear_on_start", o_timeout, 0);
    tick();
`else
    // Without the watchdog SEND waits indefinitely.
    start_run(1);
    tick();
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_sample_valid !== 1'b1 || o_timeout !== 1'b0) ok = 1'b0;
    end
    chk("no_to_wait", ok, 1);
    filter_one(0, 0, 1, 1'b0, 1'b1, samp_model[0]);
`endif

    chk("result_ack_width", rack_wide, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
